alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
Parametrised successor to the single-cycle ALU control path. It decodes ALUOp/funct, executes the single-cycle ops (ADD, SUB, AND, OR, SLT, NOR) with a registered result, and adds iterative unsigned multiply/divide (MULTU/DIVU) with HI/LO registers plus MFHI/MFLO. It sits in the EX stage of the multi-cycle datapath and stalls the control FSM through a start/busy/done handshake.

Parameters:
WIDTH, 32, operand/result/HI/LO width; must be ≥4 and even.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  request; accepted only while busy=0
alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 reserved
funct  in  6  R-type function field
a  in  WIDTH  operand rs
b  in  WIDTH  operand rt
result  out  WIDTH  registered result
zero  out  1  result==0, registered together with result
illegal  out  1  undecodable op; valid with done
busy  out  1  1 whenever state≠IDLE
done  out  1  one-cycle completion pulse
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async): state=IDLE; result=0, zero=1, illegal=0, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation abandons the op with no HI/LO update.
- Decode (combinational, sub-module): alu_op 00 → ADD; 01 → SUB.
- alu_op 10 funct map: 100000 ADD; 100010 SUB; 100100 AND; 100101 OR; 100111 NOR; 101010 SLT; 011001 MULTU; 011011 DIVU; 010000 MFHI; 010010 MFLO.
- Other funct values, or alu_op 11 → ILLEGAL.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH, no overflow trap. SLT is signed two's complement; result is 1 or 0.
- Operand capture: a, b and the decoded op are captured on the accepting edge. Later input changes have no effect.
- FSM IDLE: start=1 → single-cycle ops go to DONE; MULTU/DIVU go to EXEC with counter=0.
- FSM IDLE, DIVU with b=0 (checked on the captured operand): go directly to DONE.
- FSM EXEC: one shift-add (MULTU) or restoring-subtract (DIVU) step per cycle. After step WIDTH-1 go to DONE.
- FSM DONE: done=1 for one cycle, result/zero/illegal/hi/lo update on entry; next state IDLE.
- Start is ignored in EXEC and DONE.
- Latency: start accepted at edge N; single-cycle, ILLEGAL and divide-by-zero ops give done at cycle N+1.
- Latency: MULTU/DIVU give done at cycle N+WIDTH+1; busy=1 from N+1 up to and including the done cycle.
- MULTU: {hi,lo} = a*b, full 2·WIDTH-bit unsigned product; result=0.
- DIVU: lo=quotient, hi=remainder; result=0.
- DIVU by zero: lo=all ones, hi=a; result=0; illegal=0.
- MFHI/MFLO: result=hi/lo as they stood at acceptance; HI/LO unchanged.
- ILLEGAL: result=0, zero=1, illegal=1; HI/LO unchanged.
- Outputs other than done hold their values between operations. illegal holds until the next completion.

Decomposition:
- Shared package alu_pkg:
  - funct constants (FUNCT_ADD … FUNCT_MFLO).
  - ALUOp constants.
  - 4-bit alu_control encodings: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, MULTU 1000, DIVU 1001, MFHI 1010, MFLO 1011, ILLEGAL 1111.
  - FSM state enum IDLE/EXEC/DONE.
- One sub-module, alu_op_decode: purely combinational alu_op/funct → 4-bit code. It is reused by the existing control path.

Test Plan:
- Reset mid-MULTU: assert reset 3 cycles after start → busy=0, done never pulses, hi=lo=0 immediately (async).
- WIDTH=32: ADD a=0xFFFFFFFF, b=1, start → done at N+1, result=0, zero=1. SLT a=0xFFFFFFFE (−2), b=1 → result=1.
- WIDTH=32: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done exactly 33 cycles after acceptance, hi=0xFFFFFFFE, lo=0x00000001. Then MFHI → result=0xFFFFFFFE at N+1.
- WIDTH=8: DIVU a=200, b=7 → done after 9 cycles, lo=28, hi=4. DIVU a=0x5A, b=0 → done at N+1, lo=0xFF, hi=0x5A, illegal=0.
- Start asserted every cycle during a 32-bit MULTU → only the first is accepted. Exactly one done pulse; inputs changed mid-EXEC do not alter hi/lo.
- alu_op=10, funct=111111 and alu_op=11 → done at N+1, illegal=1, result=0, hi/lo unchanged from the prior values.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU: ALUOp, R-type funct fields,
// 4-bit alu_control codes and the execution FSM states.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

  localparam logic [3:0] CTRL_AND     = 4'b0000;
  localparam logic [3:0] CTRL_OR      = 4'b0001;
  localparam logic [3:0] CTRL_ADD     = 4'b0010;
  localparam logic [3:0] CTRL_SUB     = 4'b0110;
  localparam logic [3:0] CTRL_SLT     = 4'b0111;
  localparam logic [3:0] CTRL_NOR     = 4'b1100;
  localparam logic [3:0] CTRL_MULTU   = 4'b1000;
  localparam logic [3:0] CTRL_DIVU    = 4'b1001;
  localparam logic [3:0] CTRL_MFHI    = 4'b1010;
  localparam logic [3:0] CTRL_MFLO    = 4'b1011;
  localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct to 4-bit alu_control decode; also used by the
// existing control path.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = CTRL_ILLEGAL;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = CTRL_ADD;
      ALUOP_SUB: alu_ctrl = CTRL_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD:   alu_ctrl = CTRL_ADD;
          FUNCT_SUB:   alu_ctrl = CTRL_SUB;
          FUNCT_AND:   alu_ctrl = CTRL_AND;
          FUNCT_OR:    alu_ctrl = CTRL_OR;
          FUNCT_NOR:   alu_ctrl = CTRL_NOR;
          FUNCT_SLT:   alu_ctrl = CTRL_SLT;
          FUNCT_MULTU: alu_ctrl = CTRL_MULTU;
          FUNCT_DIVU:  alu_ctrl = CTRL_DIVU;
          FUNCT_MFHI:  alu_ctrl = CTRL_MFHI;
          FUNCT_MFLO:  alu_ctrl = CTRL_MFLO;
          default:     alu_ctrl = CTRL_ILLEGAL;
        endcase
      end
      default: alu_ctrl = CTRL_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: registered single-cycle ops plus iterative MULTU/DIVU into
// HI/LO, with a start/busy/done handshake toward the control FSM.
//
// state   | meaning
// IDLE    | waiting for start; single-cycle ops complete from here
// EXEC    | one multiply/divide step per cycle, WIDTH steps total
// DONE    | done pulse cycle; outputs already updated; back to IDLE
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dec_ctrl;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  alu_op_decode u_dec (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (dec_ctrl)
  );

  assign busy = (state != ST_IDLE);

  always_comb begin
    alu_res = '0;
    case (dec_ctrl)
      CTRL_AND:  alu_res = a & b;
      CTRL_OR:   alu_res = a | b;
      CTRL_ADD:  alu_res = a + b;
      CTRL_SUB:  alu_res = a - b;
      CTRL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      CTRL_NOR:  alu_res = ~(a | b);
      CTRL_MFHI: alu_res = hi;
      CTRL_MFLO: alu_res = lo;
      default:   alu_res = '0;
    endcase
  end

  // w_hi:w_lo is the partial product (multiplier shifts out of w_lo) or the
  // remainder:dividend pair (quotient bits shift into w_lo).
  always_comb begin
    mul_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_diff = {w_hi, w_lo[WIDTH-1]} - {1'b0, b_q};
    if (op_q == CTRL_MULTU) begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], w_lo[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      step_hi = div_diff[WIDTH-1:0];
      step_lo = {w_lo[WIDTH-2:0], 1'b1};
    end else begin
      step_hi = {w_hi[WIDTH-2:0], w_lo[WIDTH-1]};
      step_lo = {w_lo[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      op_q    <= CTRL_ILLEGAL;
      b_q     <= '0;
      w_hi    <= '0;
      w_lo    <= '0;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q <= dec_ctrl;
            b_q  <= b;
            cnt  <= '0;
            w_hi <= '0;
            w_lo <= a;
            case (dec_ctrl)
              CTRL_MULTU: state <= ST_EXEC;
              CTRL_DIVU: begin
                if (b == '0) begin
                  lo      <= '1;
                  hi      <= a;
                  result  <= '0;
                  zero    <= 1'b1;
                  illegal <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_DONE;
                end else begin
                  state <= ST_EXEC;
                end
              end
              CTRL_ILLEGAL: begin
                result  <= '0;
                zero    <= 1'b1;
                illegal <= 1'b1;
                done    <= 1'b1;
                state   <= ST_DONE;
              end
              default: begin
                result  <= alu_res;
                zero    <= (alu_res == '0);
                illegal <= 1'b0;
                done    <= 1'b1;
                state   <= ST_DONE;
              end
            endcase
          end
        end
        ST_EXEC: begin
          w_hi <= step_hi;
          w_lo <= step_lo;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            hi      <= step_hi;
            lo      <= step_lo;
            result  <= '0;
            zero    <= 1'b1;
            illegal <= 1'b0;
            done    <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
